// File: rtl/divider_seq_pkg.sv
// Shared ALU divider definitions: default width, FSM encoding and
// divide-by-zero constants used by the sequential divider and its step cell.
package divider_seq_pkg;

    localparam int DIV_WIDTH = 16;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    // Wide all-ones pattern; users slice it down to their own width (up to 64).
    localparam logic [63:0] DBZ_QUOTIENT_ALL = '1;

    function automatic int div_cnt_w(input int w);
        return $clog2(w) + 1;
    endfunction

    localparam int DIV_CNT_W = div_cnt_w(DIV_WIDTH);

endpackage

// File: rtl/divider_seq_step.sv
// One combinational restoring-division step: shift in a dividend bit,
// subtract the divisor when it fits, and report the quotient bit.
module div_step
    import divider_seq_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic [WIDTH-1:0] rem_in,
    input  logic             bit_in,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] rem_out,
    output logic             q_bit
);

    logic [WIDTH:0] shifted;

    always_comb begin
        shifted = {rem_in, bit_in};
        q_bit   = (shifted >= {1'b0, divisor});
        // rem_in < divisor keeps the result below 2**WIDTH, so a WIDTH-bit subtract is exact.
        rem_out = q_bit ? (shifted[WIDTH-1:0] - divisor) : shifted[WIDTH-1:0];
    end

endmodule

// File: rtl/divider_seq.sv
// Sequential unsigned divider: one restoring step per clock behind a
// start/busy/done handshake, with registered quotient/remainder outputs.
module divider_seq
    import divider_seq_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    localparam int CNT_W = div_cnt_w(WIDTH);
    localparam logic [WIDTH-1:0] DBZ_Q = DBZ_QUOTIENT_ALL[WIDTH-1:0];

    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] dvd_q, dvd_d;
    logic [WIDTH-1:0] dvs_q, dvs_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic [WIDTH-1:0] quot_q, quot_d;
    logic [WIDTH-1:0] remo_q, remo_d;
    logic             dbz_q, dbz_d;

    logic [WIDTH-1:0] step_rem;
    logic             step_q;

    div_step #(.WIDTH(WIDTH)) u_step (
        .rem_in  (rem_q),
        .bit_in  (dvd_q[WIDTH-1]),
        .divisor (dvs_q),
        .rem_out (step_rem),
        .q_bit   (step_q)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        dvd_d   = dvd_q;
        dvs_d   = dvs_q;
        rem_d   = rem_q;
        quot_d  = quot_q;
        remo_d  = remo_q;
        dbz_d   = dbz_q;
        case (state_q)
            ST_RUN: begin
                rem_d = step_rem;
                // Dividend bits leave at the MSB while quotient bits enter at the LSB.
                dvd_d = {dvd_q[WIDTH-2:0], step_q};
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(WIDTH - 1)) begin
                    state_d = ST_DONE;
                    quot_d  = {dvd_q[WIDTH-2:0], step_q};
                    remo_d  = step_rem;
                    dbz_d   = 1'b0;
                end
            end
            default: begin
                // IDLE and DONE both accept a new request.
                state_d = ST_IDLE;
                if (start) begin
                    dvd_d = dividend;
                    dvs_d = divisor;
                    rem_d = '0;
                    cnt_d = '0;
                    if (divisor == '0) begin
                        state_d = ST_DONE;
                        quot_d  = DBZ_Q;
                        remo_d  = dividend;
                        dbz_d   = 1'b1;
                    end else begin
                        state_d = ST_RUN;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            dvd_q   <= '0;
            dvs_q   <= '0;
            rem_q   <= '0;
            quot_q  <= '0;
            remo_q  <= '0;
            dbz_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            dvd_q   <= dvd_d;
            dvs_q   <= dvs_d;
            rem_q   <= rem_d;
            quot_q  <= quot_d;
            remo_q  <= remo_d;
            dbz_q   <= dbz_d;
        end
    end

    assign busy        = (state_q == ST_RUN);
    assign done        = (state_q == ST_DONE);
    assign quotient    = quot_q;
    assign remainder   = remo_q;
    assign div_by_zero = dbz_q;

endmodule
